// File: rtl/rr_cmerge_arbiter_if.sv
// Handshake bundle for rr_cmerge_arbiter: N payload inputs merged onto one data channel plus an index channel.
// Latency: n/a (signal container only).
// Backpressure: outs_ready/index_ready flow upstream to ins_ready through the arbiter.
//
// Ports (modport slave = arbiter side):
//   ins, ins_valid, ins_ready       : N_INPUTS requesters, payload i at [i*DATA_WIDTH +: DATA_WIDTH]
//   outs, outs_valid, outs_ready    : merged data channel
//   index, index_valid, index_ready : winner-number channel
interface rr_cmerge_arbiter_if #(
    parameter int N_INPUTS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 2
);
    logic [N_INPUTS*DATA_WIDTH-1:0] ins;
    logic [N_INPUTS-1:0]            ins_valid;
    logic [N_INPUTS-1:0]            ins_ready;
    logic [DATA_WIDTH-1:0]          outs;
    logic                           outs_valid;
    logic                           outs_ready;
    logic [INDEX_WIDTH-1:0]         index;
    logic                           index_valid;
    logic                           index_ready;

    // Arbiter side.
    modport slave (
        input  ins, ins_valid, outs_ready, index_ready,
        output ins_ready, outs, outs_valid, index, index_valid
    );

    // Environment side (upstream producers and downstream consumers).
    modport master (
        output ins, ins_valid, outs_ready, index_ready,
        input  ins_ready, outs, outs_valid, index, index_valid
    );
endinterface

// File: rtl/rr_cmerge_arbiter.sv
// Round-robin control merge: picks one valid input, eager-forks its payload to outs and its number to index.
// Latency: zero cycles, valid/payload and ins_ready are combinational from inputs and registered state.
// Backpressure: winner is locked until both outputs have accepted; ins_ready pulses only on full consumption.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rr_cmerge_arbiter_if.slave (ins/ins_valid/ins_ready, outs/outs_valid/outs_ready, index/index_valid/index_ready)
module rr_cmerge_arbiter #(
    parameter int N_INPUTS    = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_cmerge_arbiter_if.slave      bus
);

    localparam int PTR_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    // Registered state
    logic [PTR_W-1:0] r_ptr;         // highest-priority input for the next unlocked pick
    logic             r_locked;      // a winner has partially transferred and must be held
    logic [PTR_W-1:0] r_grant;       // the held winner while locked
    logic             r_done_outs;   // data channel already took the held token
    logic             r_done_index;  // index channel already took the held token

    // Combinational selection
    logic [PTR_W-1:0] w_scan_sel;
    logic             w_scan_hit;
    int               w_idx;
    logic [PTR_W-1:0] w_sel;
    logic             w_any;
    logic             w_ok_outs;
    logic             w_ok_index;
    logic             w_consume;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Cyclic scan starting at r_ptr; first valid input found wins.
    always_comb begin
        w_scan_sel = '0;
        w_scan_hit = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < N_INPUTS; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_INPUTS) begin
                w_idx = w_idx - N_INPUTS;
            end
            if (!w_scan_hit && bus.ins_valid[w_idx]) begin
                w_scan_hit = 1'b1;
                w_scan_sel = PTR_W'(w_idx);
            end
        end
    end

    // A locked winner is assumed still valid (elastic protocol), so other
    // inputs cannot preempt it.
    assign w_sel = r_locked ? r_grant : w_scan_sel;
    assign w_any = r_locked | w_scan_hit;

    assign bus.outs        = bus.ins[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.index       = w_any ? INDEX_WIDTH'(w_sel) : '0;
    // Valids depend only on ins_valid and state: no ready-to-valid path.
    assign bus.outs_valid  = w_any & ~r_done_outs;
    assign bus.index_valid = w_any & ~r_done_index;

    assign w_ok_outs  = r_done_outs  | (bus.outs_valid  & bus.outs_ready);
    assign w_ok_index = r_done_index | (bus.index_valid & bus.index_ready);
    assign w_consume  = w_any & w_ok_outs & w_ok_index;

    // One-hot ready to the winner only in the cycle the token completes.
    always_comb begin
        bus.ins_ready = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            bus.ins_ready[i] = w_consume && (w_sel == PTR_W'(i));
        end
    end

    // Consumed input drops to lowest priority; explicit wrap handles
    // non-power-of-two N_INPUTS and keeps the pointer at 0 for one input.
    assign w_ptr_nxt = (w_sel == PTR_W'(N_INPUTS - 1)) ? '0 : (w_sel + PTR_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_locked     <= 1'b0;
            r_grant      <= '0;
            r_done_outs  <= 1'b0;
            r_done_index <= 1'b0;
        end else if (w_consume) begin
            r_ptr        <= w_ptr_nxt;
            r_locked     <= 1'b0;
            r_done_outs  <= 1'b0;
            r_done_index <= 1'b0;
        end else if (w_any) begin
            // Partial transfer: hold the winner and remember which side finished.
            r_locked     <= 1'b1;
            r_grant      <= w_sel;
            r_done_outs  <= w_ok_outs;
            r_done_index <= w_ok_index;
        end
    end

endmodule
